// File: rtl/irq_pending_ctrl_if.sv
// Valid/ready handshake carrying the offered interrupt index.
// master = controller side, slave = consumer side.
interface irq_pending_ctrl_if #(
  parameter int ID_W = 3
);
  logic            irq_valid;
  logic [ID_W-1:0] irq_id;
  logic            irq_ready;

  modport master (output irq_valid, output irq_id, input irq_ready);
  modport slave  (input irq_valid, input irq_id, output irq_ready);
endinterface

// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: synchronises raw lines, latches rising edges as pending
// bits, feeds the external priority encoder and offers its index downstream.
module irq_pending_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               ovr_clr,
  input  logic [ID_W-1:0]    enc_idx,
  output logic [NUM_IRQ-1:0] pend_out,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] overrun,
  irq_pending_ctrl_if.master irq
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_IRQ-1:0] s1, s2, s3;
  logic [NUM_IRQ-1:0] rise, clr;

  // s1/s2 form the metastability synchroniser; s3 is the edge-detect history.
  // A line already high at reset release therefore looks like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // so this chain shifts one stage per clock instead of collapsing.
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign pend_out = pending & ~irq_mask;

  // Set wins over the accept clear; an edge on a bit being cleared is not an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      overrun <= (overrun & ~{NUM_IRQ{ovr_clr}}) | (rise & pending & ~clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (|pend_out) begin
          id_d    = enc_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        // The offered id is frozen; an accept clears it even if since masked.
        if (irq.irq_ready) begin
          clr     = NUM_IRQ'(1) << id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Both outputs come straight from flops: no combinational path from irq_ready.
  assign irq.irq_valid = (state_q == OFFER);
  assign irq.irq_id    = id_q;

endmodule
